// File: rtl/regf_pkg.sv
// Shared widths and bypass-select encoding for the 2-write/2-read register file.
package regf_pkg;
    localparam int REGF_DWIDTH = 32;
    localparam int REGF_AWIDTH = 5;
    localparam int REGF_DEPTH  = 32;

    typedef enum logic [1:0] {
        BYP_RF = 2'd0,
        BYP_C  = 2'd1,
        BYP_D  = 2'd2
    } byp_sel_e;
endpackage

// File: rtl/regf_rd_port.sv
// One registered read port: C/D bypass mux, data capture and ready flag.
// With REGF_ZERO_REG_EN defined, address 0 never forwards.
module regf_rd_port
    import regf_pkg::*;
#(
    parameter int DWIDTH = REGF_DWIDTH,
    parameter int AWIDTH = REGF_AWIDTH,
    parameter int DEPTH  = REGF_DEPTH
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              i_halt,
    input  logic              i_en,
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_rf_data,
    input  logic              i_rf_busy,
    input  logic              i_wec,
    input  logic [AWIDTH-1:0] i_addrc,
    input  logic [DWIDTH-1:0] i_dc,
    input  logic              i_wed,
    input  logic [AWIDTH-1:0] i_addrd,
    input  logic [DWIDTH-1:0] i_dd,
    output logic [DWIDTH-1:0] o_q,
    output logic              o_rdy
);
    localparam logic [AWIDTH:0] LP_DEPTH = DEPTH[AWIDTH:0];

    logic              w_ok;
    logic              w_fwd_ok;
    logic              w_hit_c;
    logic              w_hit_d;
    logic              w_rdy;
    byp_sel_e          w_sel;
    logic [DWIDTH-1:0] w_data;
    logic [DWIDTH-1:0] r_q;
    logic              r_rdy;

    assign w_ok = ({1'b0, i_addr} < LP_DEPTH);
`ifdef REGF_ZERO_REG_EN
    assign w_fwd_ok = w_ok && (i_addr != '0);
`else
    assign w_fwd_ok = w_ok;
`endif

    // Out-of-range addresses never forward: those writes are dropped anyway.
    assign w_hit_c = i_wec && (i_addrc == i_addr) && w_fwd_ok;
    assign w_hit_d = i_wed && (i_addrd == i_addr) && w_fwd_ok;
    assign w_rdy   = !i_rf_busy || w_hit_c || w_hit_d;

    always_comb begin
        w_sel = BYP_RF;
        if (w_hit_c)
            w_sel = BYP_C;
        else if (w_hit_d)
            w_sel = BYP_D;
    end

    always_comb begin
        case (w_sel)
            BYP_C:   w_data = i_dc;
            BYP_D:   w_data = i_dd;
            default: w_data = i_rf_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_q   <= '0;
            r_rdy <= 1'b1;
        end else if (i_en && !i_halt) begin
            r_q   <= w_data;
            r_rdy <= w_rdy;
        end
    end

    assign o_q   = r_q;
    assign o_rdy = r_rdy;
endmodule

// File: rtl/regf_2w2r_sb.sv
// Two-write/two-read register file with bypassed registered reads and a
// port-D load scoreboard. REGF_ZERO_REG_EN hardwires register 0 to zero.
module regf_2w2r_sb
    import regf_pkg::*;
#(
    parameter int DWIDTH = REGF_DWIDTH,
    parameter int AWIDTH = REGF_AWIDTH,
    parameter int DEPTH  = REGF_DEPTH
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              halt,
    input  logic [AWIDTH-1:0] addra,
    input  logic              a_en,
    input  logic [AWIDTH-1:0] addrb,
    input  logic              b_en,
    input  logic [AWIDTH-1:0] addrc,
    input  logic [DWIDTH-1:0] dc,
    input  logic              wec,
    input  logic [AWIDTH-1:0] addrd,
    input  logic [DWIDTH-1:0] dd,
    input  logic              wed,
    input  logic [AWIDTH-1:0] res_addr,
    input  logic              res_en,
    output logic [DWIDTH-1:0] qra,
    output logic [DWIDTH-1:0] qrb,
    output logic              rdya,
    output logic              rdyb,
    output logic [AWIDTH:0]   busy_cnt
);
    localparam logic [AWIDTH:0] LP_DEPTH = DEPTH[AWIDTH:0];

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [AWIDTH:0]   r_busy_cnt;

    logic [DEPTH-1:0]  w_we_c;
    logic [DEPTH-1:0]  w_we_d;
    logic [DEPTH-1:0]  w_set;
    logic [DEPTH-1:0]  w_clr;
    logic [AWIDTH:0]   w_pop;
    logic              w_ok_a;
    logic              w_ok_b;
    logic [DWIDTH-1:0] w_rf_a;
    logic [DWIDTH-1:0] w_rf_b;
    logic              w_busy_a;
    logic              w_busy_b;

    // Decoding only indices below DEPTH drops out-of-range writes/reservations.
    always_comb begin
        w_we_c = '0;
        w_we_d = '0;
        w_set  = '0;
        w_clr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_we_c[i] = wec && (addrc == AWIDTH'(i));
            w_we_d[i] = wed && (addrd == AWIDTH'(i));
            w_set[i]  = res_en && !halt && (res_addr == AWIDTH'(i));
            w_clr[i]  = wed && (addrd == AWIDTH'(i));
        end
`ifdef REGF_ZERO_REG_EN
        w_we_c[0] = 1'b0;
        w_we_d[0] = 1'b0;
        w_set[0]  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we_c[i])
                    r_mem[i] <= dc;
                else if (w_we_d[i])
                    r_mem[i] <= dd;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DEPTH; i++)
            w_pop = w_pop + {{AWIDTH{1'b0}}, r_busy[i]};
    end

    // A new reservation beats a same-cycle return to the same register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_set | (r_busy & ~w_clr);
            r_busy_cnt <= w_pop;
        end
    end

    assign w_ok_a   = ({1'b0, addra} < LP_DEPTH);
    assign w_ok_b   = ({1'b0, addrb} < LP_DEPTH);
    assign w_rf_a   = w_ok_a ? r_mem[addra] : '0;
    assign w_rf_b   = w_ok_b ? r_mem[addrb] : '0;
    assign w_busy_a = w_ok_a && r_busy[addra];
    assign w_busy_b = w_ok_b && r_busy[addrb];

    regf_rd_port #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_rd_a (
        .clk       (clk),
        .reset_b   (reset_b),
        .i_halt    (halt),
        .i_en      (a_en),
        .i_addr    (addra),
        .i_rf_data (w_rf_a),
        .i_rf_busy (w_busy_a),
        .i_wec     (wec),
        .i_addrc   (addrc),
        .i_dc      (dc),
        .i_wed     (wed),
        .i_addrd   (addrd),
        .i_dd      (dd),
        .o_q       (qra),
        .o_rdy     (rdya)
    );

    regf_rd_port #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_rd_b (
        .clk       (clk),
        .reset_b   (reset_b),
        .i_halt    (halt),
        .i_en      (b_en),
        .i_addr    (addrb),
        .i_rf_data (w_rf_b),
        .i_rf_busy (w_busy_b),
        .i_wec     (wec),
        .i_addrc   (addrc),
        .i_dc      (dc),
        .i_wed     (wed),
        .i_addrd   (addrd),
        .i_dd      (dd),
        .o_q       (qrb),
        .o_rdy     (rdyb)
    );

    assign busy_cnt = r_busy_cnt;
endmodule

// File: doc/regf_2w2r_sb.md
Name: regf_2w2r_sb

Overview:
- Parametrised successor of the SXP synchronous register file: 2 read ports (A, B) and 2 write ports (C = ALU writeback, D = late load/extended-op return).
- Read data is registered, with one cycle of latency and full write-to-read bypass.
- A per-register scoreboard tracks outstanding port-D writes, so decode can stall on load-use hazards.
- Sits between the SXP decode stage (reads, reservations) and the writeback stages (C, D).

Parameters:
- DWIDTH, 32, data width in bits.
- AWIDTH, 5, register address width.
- DEPTH, 32, number of registers; must be ≤ 2**AWIDTH.

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- halt  in  1  system-wide halt; freezes read registers and reservations
- addra  in  AWIDTH  port A read address
- a_en  in  1  port A read enable
- addrb  in  AWIDTH  port B read address
- b_en  in  1  port B read enable
- addrc  in  AWIDTH  port C write address
- dc  in  DWIDTH  port C write data
- wec  in  1  port C write enable
- addrd  in  AWIDTH  port D write address
- dd  in  DWIDTH  port D write data
- wed  in  1  port D write enable; also clears the reservation of addrd
- res_addr  in  AWIDTH  scoreboard reservation address
- res_en  in  1  reserve res_addr (port-D write outstanding)
- qra  out  DWIDTH  port A registered read data
- qrb  out  DWIDTH  port B registered read data
- rdya  out  1  registered: qra was not pending when captured
- rdyb  out  1  registered: qrb was not pending when captured
- busy_cnt  out  AWIDTH+1  number of registers currently reserved

Behaviour:
- Reset: clk and reset_b, asynchronous, active-low. All registers, qra, qrb and busy bits → 0; rdya/rdyb → 1; busy_cnt → 0.
- Writes commit at posedge clk, independent of halt; writeback always drains.
- Simultaneous wec and wed to the same address: C wins. C is the younger instruction, so this resolves WAW.
- Addresses ≥ DEPTH: writes ignored, reads return 0, no reservation is made.
- Read, registered: at posedge with a_en && !halt, qra is loaded with the bypassed value; otherwise qra holds.
  - Bypass priority: dc if (wec && addrc==addra); else dd if (wed && addrd==addra); else reg_file[addra]. Port B is identical.
  - Latency: address in cycle N, data valid after the edge ending cycle N. A write in cycle N is visible to a read issued in cycle N.
- rdya is loaded together with qra:
  - value = !busy[addra] || (wed && addrd==addra) || (wec && addrc==addra).
  - Decode uses rdya=0 to replay the read.
- Scoreboard busy[DEPTH-1:0]:
  - wed clears busy[addrd].
  - res_en && !halt sets busy[res_addr].
  - Set and clear on the same address in the same cycle: set wins (new load issued).
  - Port C writes do not affect busy.
- busy_cnt is a registered popcount of busy. It updates the cycle after any change and never exceeds DEPTH.
- reset_b asserted mid-operation clears everything immediately, including pending reservations. In-flight port-D returns after reset are written but find busy already 0.

Optional Feature:
- REGF_ZERO_REG_EN defined:
  - register 0 is hardwired to 0; writes to address 0 are ignored on both ports;
  - bypass never forwards for address 0;
  - a reservation of address 0 is ignored; rdy is always 1 for address 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package regf_pkg holds:
  - default widths (REGF_DWIDTH=32, REGF_AWIDTH=5, REGF_DEPTH=32);
  - a bypass-select enum (BYP_RF, BYP_C, BYP_D).
- One sub-module, regf_rd_port: per-port bypass mux, capture register and rdy flag. It is instantiated twice (A, B).
- Storage and scoreboard stay in the top level.

Test Plan:
- Reset check: assert reset_b=0 mid-stream → qra=qrb=0, rdya=rdyb=1, busy_cnt=0, all registers read 0.
- Bypass priority: wec addrc=5 dc=0x11, wed addrd=5 dd=0x22, a_en addra=5, same cycle → qra=0x11 next cycle; register 5 holds 0x11 afterwards.
- Load-use hazard: res_en res_addr=7, next cycle read A addr 7 → rdya=0, busy_cnt=1. Then wed addrd=7 dd=0xABCD with same-cycle read → qra=0xABCD, rdya=1; busy_cnt=0 one cycle later.
- Set-wins: busy[3]=1, same cycle wed addrd=3 and res_en res_addr=3 → busy[3] stays 1, busy_cnt unchanged.
- Halt: halt=1 with a_en addra=2 and wec addrc=2 dc=0x55 → qra holds its old value, register 2 = 0x55. A res_en asserted during halt is ignored.
- With REGF_ZERO_REG_EN: wec addrc=0 dc=0xFFFF, read addr 0 → qra=0, rdya=1.
